// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parameterised UART receiver.
// Holds the receive FSM state encoding, parity-mode constants, the legal
// range limits for frame length and baud divisor, and a frame-length clamp.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_BITS = 5;
  localparam int unsigned MIN_BAUD = 4;

  // Out-of-range requests snap to the nearest legal frame length.
  function automatic logic [4:0] clamp_bits(input logic [4:0] bits,
                                            input int unsigned max_bits);
    if (bits < 5'(MIN_BITS)) return 5'(MIN_BITS);
    if (32'(bits) > max_bits) return 5'(max_bits);
    return bits;
  endfunction

endpackage

// File: rtl/uart_rx_param_baud_tick.sv
// uart_baud_tick: sample-strobe generator for the UART receiver.
// On start it latches the bit period and preloads a half-bit count so the
// first strobe lands mid start bit; afterwards it strobes once per bit period.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   baud      - cycles per bit (already clamped by the caller), latched on start
//   start     - begin a new frame (reload half-bit count)
//   run       - count while a frame is in progress
//   tick      - one-cycle sample strobe
module uart_baud_tick #(
  parameter int unsigned BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud,
  input  logic              start,
  input  logic              run,
  output logic              tick
);

  logic [BAUD_W-1:0] reload;
  logic [BAUD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= '0;
      cnt    <= '0;
    end else if (start) begin
      reload <= baud - BAUD_W'(1);
      cnt    <= (baud >> 1) - BAUD_W'(1);
    end else if (run) begin
      if (cnt == '0) cnt <= reload;
      else           cnt <= cnt - BAUD_W'(1);
    end
  end

  assign tick = run && !start && (cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with runtime frame format.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   baud                - cycles per bit (values below 4 act as 4)
//   rx_en               - receiver enable; dropping it aborts a frame
//   rx_in               - asynchronous serial line, idle high
//   cfg_bits/parity/stop- frame format, latched at the start edge
//   rx_data             - received word, LSB-aligned, unused MSBs zero
//   rx_valid/rx_ready   - output handshake on the holding register
//   parity_err/frame_err- status qualified by rx_valid
//   overrun             - one-cycle pulse when a completed frame is dropped
//   busy                - high whenever the FSM is not idle
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int unsigned MAX_BITS = 10,
  parameter int unsigned BAUD_W   = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BAUD_W-1:0]   baud,
  input  logic                rx_en,
  input  logic                rx_in,
  input  logic [4:0]          cfg_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam logic [4:0] MAX_BITS5 = 5'(MAX_BITS);

  logic sync1, sync2, prev;
  logic fall;

  rx_state_t state, next_state;

  logic [BAUD_W-1:0]   baud_eff;
  logic [4:0]          bits_l;
  logic [4:0]          bit_idx;
  logic [1:0]          par_l;
  logic                stop_cnt;
  logic [MAX_BITS-1:0] shift_r;
  logic                par_acc, par_err_r, frm_err_r;
  logic                start_det, tick, done;
  logic                par_on, last_data;
  logic [MAX_BITS-1:0] word;

  // Two-flop synchroniser plus one more flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall     = prev && !sync2;
  assign baud_eff = (baud < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : baud;

  uart_baud_tick #(.BAUD_W(BAUD_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .baud  (baud_eff),
    .start (start_det),
    .run   (state != ST_IDLE),
    .tick  (tick)
  );

  assign par_on    = (par_l == PAR_EVEN) || (par_l == PAR_ODD);
  assign last_data = (bit_idx == bits_l - 5'd1);
  assign busy      = (state != ST_IDLE);
  // Bits enter at the MSB end, so a short frame sits high and is shifted down.
  assign word      = shift_r >> (MAX_BITS5 - bits_l);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_det  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:   if (rx_en && fall) begin
                   start_det  = 1'b1;
                   next_state = ST_START;
                 end
      ST_START:  if (tick) next_state = sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && last_data) next_state = par_on ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) next_state = ST_STOP;
      ST_STOP:   if (tick && !stop_cnt) begin
                   next_state = ST_IDLE;
                   done       = 1'b1;
                 end
      default:   next_state = ST_IDLE;
    endcase
    if (state != ST_IDLE && !rx_en) begin
      next_state = ST_IDLE;
      done       = 1'b0;
    end
  end

  // Frame datapath: format latched at the start edge, bits captured on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_l    <= 5'(MIN_BITS);
      bit_idx   <= '0;
      par_l     <= PAR_NONE;
      stop_cnt  <= 1'b0;
      shift_r   <= '0;
      par_acc   <= 1'b0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else if (start_det) begin
      bits_l    <= clamp_bits(cfg_bits, MAX_BITS);
      bit_idx   <= '0;
      par_l     <= cfg_parity;
      stop_cnt  <= cfg_stop;
      shift_r   <= '0;
      par_acc   <= 1'b0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_DATA: begin
          shift_r <= {sync2, shift_r[MAX_BITS-1:1]};
          par_acc <= par_acc ^ sync2;
          bit_idx <= bit_idx + 5'd1;
        end
        ST_PARITY: par_err_r <= sync2 != ((par_l == PAR_ODD) ? ~par_acc : par_acc);
        ST_STOP: begin
          if (!sync2) frm_err_r <= 1'b1;
          stop_cnt <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Holding register with overrun protection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= word;
          parity_err <= par_err_r;
          frame_err  <= frm_err_r | ~sync2;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int MAXB = 10;
  localparam int BW   = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [BW-1:0]   baud = BW'(20);
  logic            rx_en = 1'b1;
  logic            rx_in = 1'b1;
  logic [4:0]      cfg_bits = 5'd8;
  logic [1:0]      cfg_parity = 2'b00;
  logic            cfg_stop = 1'b0;
  logic [MAXB-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready = 1'b1;
  logic            parity_err, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_param #(.MAX_BITS(MAXB), .BAUD_W(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud       (baud),
    .rx_en      (rx_en),
    .rx_in      (rx_in),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop   (cfg_stop),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  typedef struct packed {
    logic [MAXB-1:0] data;
    logic            perr;
    logic            ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a word is consumed on the edge where rx_valid && rx_ready.
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (!rst && rx_valid && rx_ready) begin
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 32'(rx_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("data", 32'(rx_data), 32'(mon_e.data));
        check_val("parity_err", 32'(parity_err), 32'(mon_e.perr));
        check_val("frame_err", 32'(frame_err), 32'(mon_e.ferr));
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    @(posedge clk);
    #1 rx_in = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_raw(input logic [15:0] data, input int nbits, input int b,
                          input logic [1:0] pm, input int nstop,
                          input logic bad_par, input logic bad_stop);
    logic p;
    p = 1'b0;
    @(posedge clk);
    #1 rx_in = 1'b0;
    start_cyc = cyc;
    repeat (b - 1) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(data[i], b);
      p = p ^ data[i];
    end
    if (pm == 2'b01 || pm == 2'b10)
      drive_bit(((pm == 2'b10) ? ~p : p) ^ bad_par, b);
    for (int s = 0; s < nstop; s++)
      drive_bit((s == nstop - 1 && bad_stop) ? 1'b0 : 1'b1, b);
    drive_bit(1'b1, b);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // cfg_v is what the DUT is told; nbits is what the line actually carries.
  task automatic frame(input logic [15:0] data, input logic [4:0] cfg_v, input int nbits,
                       input logic [BW-1:0] baud_v, input int b, input logic [1:0] pm,
                       input int nstop, input logic bad_par, input logic bad_stop);
    exp_t e;
    baud       = baud_v;
    cfg_bits   = cfg_v;
    cfg_parity = pm;
    cfg_stop   = (nstop == 2);
    e.data = MAXB'(data & ((16'd1 << nbits) - 16'd1));
    e.perr = (pm == 2'b01 || pm == 2'b10) ? bad_par : 1'b0;
    e.ferr = bad_stop;
    exp_q.push_back(e);
    send_raw(data, nbits, b, pm, nstop, bad_par, bad_stop);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [15:0] rd;
    logic [1:0] rp;
    int rs;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_data", 32'(rx_data), 32'd0);
    check_val("rst_valid", 32'(rx_valid), 32'd0);
    check_val("rst_perr", 32'(parity_err), 32'd0);
    check_val("rst_ferr", 32'(frame_err), 32'd0);
    check_val("rst_ovr", 32'(overrun), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // 8N1 0xA5, with latency from start edge to rx_valid
    frame(16'h00A5, 5'd8, 8, BW'(20), 20, 2'b00, 1, 1'b0, 1'b0);
    lat = last_valid_cyc - start_cyc;
    check_val("latency_window", 32'(lat >= 185 && lat <= 200), 32'd1);

    // 10N1, bits 1,1,0,1,1,1,0,1,0,0 LSB first
    frame(16'h00BB, 5'd10, 10, BW'(20), 20, 2'b00, 1, 1'b0, 1'b0);
    // 8E1 data 0x01 with wrong parity bit
    frame(16'h0001, 5'd8, 8, BW'(20), 20, 2'b01, 1, 1'b1, 1'b0);
    // 8N2 with second stop low
    frame(16'h003C, 5'd8, 8, BW'(20), 20, 2'b00, 2, 1'b0, 1'b1);
    // good odd and even parity
    frame(16'h005A, 5'd8, 8, BW'(20), 20, 2'b10, 1, 1'b0, 1'b0);
    frame(16'h007F, 5'd8, 8, BW'(20), 20, 2'b01, 1, 1'b0, 1'b0);
    // baud 2 acts as 4; cfg_bits 3 acts as 5
    frame(16'h0015, 5'd3, 5, BW'(2), 4, 2'b00, 1, 1'b0, 1'b0);
    // cfg_bits 20 clamps to MAX_BITS
    frame(16'h03A5, 5'd20, 10, BW'(16), 16, 2'b00, 1, 1'b0, 1'b0);
    // parity mode 11 behaves as none
    frame(16'h0096, 5'd8, 8, BW'(20), 20, 2'b11, 1, 1'b0, 1'b0);
    // randomised 8-bit frames
    for (int k = 0; k < 4; k++) begin
      rd = 16'($urandom_range(0, 255));
      rp = 2'($urandom_range(0, 2));
      rs = int'($urandom_range(1, 2));
      frame(rd, 5'd8, 8, BW'(12), 12, rp, rs, 1'($urandom_range(0, 1)), 1'b0);
    end

    // 5-cycle glitch: false start, nothing delivered
    baud = BW'(20);
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_val("glitch_busy", 32'(busy), 32'd0);
    check_val("glitch_valid", 32'(rx_valid), 32'd0);

    // rx_en dropped mid-frame aborts
    cfg_bits = 5'd8;
    cfg_parity = 2'b00;
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check_val("abort_busy_before", 32'(busy), 32'd1);
    #1 rx_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("abort_busy_after", 32'(busy), 32'd0);
    rx_in = 1'b1;
    repeat (10) @(posedge clk);
    #1 rx_en = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check_val("abort_valid", 32'(rx_valid), 32'd0);

    // overrun: two frames with rx_ready low
    check_val("ovr_none_yet", 32'(ovr_cnt), 32'd0);
    #1 rx_ready = 1'b0;
    cfg_stop = 1'b0;
    send_raw(16'h0011, 8, 20, 2'b00, 1, 1'b0, 1'b0);
    send_raw(16'h0022, 8, 20, 2'b00, 1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("ovr_count", 32'(ovr_cnt), 32'd1);
    check_val("ovr_valid", 32'(rx_valid), 32'd1);
    check_val("ovr_data", 32'(rx_data), 32'h11);

    // reset in the middle of a third frame
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst2_data", 32'(rx_data), 32'd0);
    check_val("rst2_valid", 32'(rx_valid), 32'd0);
    check_val("rst2_perr", 32'(parity_err), 32'd0);
    check_val("rst2_ferr", 32'(frame_err), 32'd0);
    check_val("rst2_ovr", 32'(overrun), 32'd0);
    check_val("rst2_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    rx_ready = 1'b1;
    repeat (30) @(posedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter MAX_BITS, default 10: maximum data bits per frame (legal 5..16).
REQ-002 SHALL have parameter BAUD_W, default 20: width of the baud divisor.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port baud, input, BAUD_W: clock cycles per bit.
REQ-006 SHALL have port rx_en, input, 1: receiver enable.
REQ-007 SHALL have port rx_in, input, 1: asynchronous serial line, idle high.
REQ-008 SHALL have port cfg_bits, input, 5: data bits per frame (5..MAX_BITS).
REQ-009 SHALL have port cfg_parity, input, 2: parity mode (00 none, 01 even, 10 odd, 11 treated as none).
REQ-010 SHALL have port cfg_stop, input, 1: stop bits (0 one, 1 two).
REQ-011 SHALL have port rx_data, output, MAX_BITS: received word, LSB-aligned, unused MSBs zero.
REQ-012 SHALL have ports rx_valid (output, 1) and rx_ready (input, 1): output handshake.
REQ-013 SHALL have ports parity_err and frame_err (outputs, 1): status qualified by rx_valid.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-016 SHALL pass rx_in through a two-flop synchroniser before any use; all latencies below count from the synchronised signal.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on a synchronised high-to-low transition while rx_en=1; cfg_bits, cfg_parity, cfg_stop and baud SHALL be latched at that point and held for the frame.
REQ-019 START SHALL sample at baud>>1 cycles; low -> DATA, high -> IDLE with no output (false start).
REQ-020 DATA SHALL sample every baud cycles after the start mid-sample, LSB first, for cfg_bits bits.
REQ-021 PARITY (skipped when parity is none) SHALL sample one bit; parity_err=1 if the received bit mismatches even/odd parity of the data bits.
REQ-022 STOP SHALL sample one or two stop bits; any low stop sample sets frame_err, and sampling continues to the configured count.
REQ-023 One cycle after the last stop sample SHALL load rx_data/parity_err/frame_err, assert rx_valid and return to IDLE.
REQ-024 rx_valid SHALL remain high until the cycle rx_ready=1 is sampled; the holding register then clears rx_valid.
REQ-025 If a frame completes while rx_valid=1 and rx_ready=0, SHALL keep the old word and pulse overrun; if rx_ready=1 in the same cycle, SHALL load the new word without overrun.
REQ-026 rx_en deasserted mid-frame SHALL abort to IDLE next cycle, discarding the partial frame; the holding register is unaffected.
REQ-027 baud values below 4 SHALL be treated as 4; cfg_bits outside 5..MAX_BITS SHALL clamp to the nearest legal value.
REQ-028 The bit counter SHALL count down from the latched baud-1 and reload at zero; no free-running baud clock output.

Reset
REQ-029 On rst SHALL enter IDLE; rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, synchroniser flops=1.
REQ-030 rst mid-frame SHALL discard the frame and any held word.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding and parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-032 A sub-module uart_baud_tick (down-counter with reload and mid-bit start) SHALL generate the sample strobes.

Verification
REQ-033 baud=20, 8N1, send 0xA5 -> rx_valid with rx_data=0x0A5, no errors, ~190 cycles after the start edge.
REQ-034 baud=20, cfg_bits=10, no parity, data bits 1,1,0,1,1,1,0,1,0,0 -> rx_data=0x0BB.
REQ-035 8E1, data 0x01, parity bit 0 -> rx_valid with parity_err=1, rx_data=0x01.
REQ-036 8N2, second stop bit low -> frame_err=1.
REQ-037 Low glitch of 5 cycles at baud=20 -> no rx_valid, FSM back in IDLE.
REQ-038 Two frames with rx_ready held 0 -> first word retained, overrun pulses once; rst asserted mid-third-frame -> all outputs zero.
